// File: rtl/dm_pkg.sv
// Shared types and helpers for the dm_lsu_mem load/store data memory.
//   funct3_e    : load/store width encodings (instruction bits 14:12)
//   dm_req_t    : one request as seen on the request port
//   dm_resp_t   : one response beat (valid, error, extended load data)
//   byte_en     : store byte-enable mask for a width and byte lane
//   store_data  : replicates right-aligned store data onto every lane
//   load_extend : selects and sign/zero-extends a load from a RAM word
package dm_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dm_req_t;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] rdata;
  } dm_resp_t;

  function automatic logic [3:0] byte_en(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_B:    byte_en = 4'b0001 << lane;
      F3_H:    byte_en = lane[1] ? 4'b1100 : 4'b0011;
      F3_W:    byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  endfunction

  // Replicating the low byte/half onto all lanes lets the byte enables alone
  // pick the destination lane; no shifter is needed on the write path.
  function automatic logic [31:0] store_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B:    store_data = {4{wdata[7:0]}};
      F3_H:    store_data = {2{wdata[15:0]}};
      default: store_data = wdata;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] funct3, input logic [1:0] lane,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    load_extend = {{24{b[7]}}, b};
      F3_BU:   load_extend = {24'h0, b};
      F3_H:    load_extend = {{16{h[15]}}, h};
      F3_HU:   load_extend = {16'h0, h};
      F3_W:    load_extend = word;
      default: load_extend = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dm_lsu_mem_ram.sv
// dm_byte_ram: word-organised RAM built from four byte lanes.
//   clk   : clock
//   be    : per-lane write enable (bit n writes wdata[8n+7:8n])
//   waddr : word write address
//   wdata : write data
//   raddr : word read address
//   rdata : registered read data, one cycle after raddr is sampled
// A read and write to the same word on the same edge returns the old word.
module dm_byte_ram #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [3:0]    be,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [3:0][7:0] mem [2**AW];

  // NOTE: the storage array has no reset (a RAM macro cannot be reset); the
  // top clears it with a zero-fill sequence. Sequential state uses <= so all
  // registers sample the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    for (int l = 0; l < 4; l++) begin
      if (be[l]) mem[waddr][l] <= wdata[8*l +: 8];
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dm_lsu_mem.sv
// dm_lsu_mem: pipelined RV32 load/store data memory for the MEM stage.
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : request handshake (accepted when both high)
//   req_we                : 1 = store, 0 = load
//   req_funct3            : width/extension encoding (instr[14:12])
//   req_addr, req_wdata   : byte address, right-aligned store data
//   resp_valid            : one strobe per accepted request, READ_LAT later
//   resp_rdata, resp_err  : extended load data / illegal-request flag
//   init_done             : post-reset zero fill complete
// Build option: define DM_MISALIGN_TRAP_EN to flag misaligned half/word
// accesses as errors; otherwise they are aligned down.
module dm_lsu_mem
  import dm_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int READ_LAT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DM_ADDRESS-1:0] req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  output logic                  resp_err,
  output logic                  init_done
);

  localparam int AW    = DM_ADDRESS - 2;
  localparam int DEPTH = 2**AW;

  if (DATA_W != 32) begin : g_bad_width
    $error("dm_lsu_mem: DATA_W must be 32");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_lat
    $error("dm_lsu_mem: READ_LAT must be 1..4");
  end

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e        state, state_next;
  logic [AW-1:0] fill, fill_next;
  logic          accept, bad;
  logic [1:0]    lane;
  logic [AW-1:0] word_idx;
  logic [3:0]    ram_be;
  logic [AW-1:0] ram_waddr;
  logic [31:0]   ram_wdata, ram_rdata;

  assign lane     = req_addr[1:0];
  assign word_idx = req_addr[DM_ADDRESS-1:2];
  assign accept   = req_valid && (state == S_RUN);

  // NOTE: every signal written in an always_comb gets a value before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    bad = req_we ? !(req_funct3 inside {F3_B, F3_H, F3_W})
                 : !(req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
`ifdef DM_MISALIGN_TRAP_EN
    if (req_funct3[1:0] == 2'b01 && lane[0]) bad = 1'b1;  // LH/LHU/SH odd
    if (req_funct3 == F3_W && lane != 2'b00) bad = 1'b1;
`endif
  end

  always_comb begin
    state_next = state;
    fill_next  = fill;
    req_ready  = 1'b0;
    init_done  = 1'b0;
    ram_be     = 4'b0000;
    ram_waddr  = word_idx;
    ram_wdata  = store_data(req_funct3, req_wdata);
    case (state)
      S_INIT: begin
        ram_be    = 4'b1111;
        ram_waddr = fill;
        ram_wdata = 32'h0;
        fill_next = fill + 1'b1;
        if (fill == AW'(DEPTH - 1)) state_next = S_RUN;
      end
      S_RUN: begin
        req_ready = 1'b1;
        init_done = 1'b1;
        if (req_valid && req_we && !bad) ram_be = byte_en(req_funct3, lane);
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_INIT;
      fill  <= '0;
    end else begin
      state <= state_next;
      fill  <= fill_next;
    end
  end

  // Stores commit and loads sample the RAM on the same acceptance edge, so a
  // load accepted after a store always reads the post-store word: write-first
  // behaviour falls out without a bypass mux, and one request per cycle rules
  // out a same-edge store/load pair.
  dm_byte_ram #(.AW(AW)) u_ram (
    .clk   (clk),
    .be    (ram_be),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (word_idx),
    .rdata (ram_rdata)
  );

  logic       m_valid, m_err, m_store;
  logic [2:0] m_funct3;
  logic [1:0] m_lane;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_err    <= 1'b0;
      m_store  <= 1'b0;
      m_funct3 <= '0;
      m_lane   <= '0;
    end else begin
      m_valid <= accept;
      if (accept) begin
        m_err    <= bad;
        m_store  <= req_we;
        m_funct3 <= req_funct3;
        m_lane   <= lane;
      end
    end
  end

  dm_resp_t s0, resp;

  always_comb begin
    s0 = '0;
    if (m_valid) begin
      s0.valid = 1'b1;
      s0.err   = m_err;
      if (!m_err && !m_store) s0.rdata = load_extend(m_funct3, m_lane, ram_rdata);
    end
  end

  if (READ_LAT > 1) begin : g_pipe
    dm_resp_t pipe [READ_LAT-1];
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < READ_LAT - 1; k++) pipe[k] <= '0;
      end else begin
        pipe[0] <= s0;
        for (int k = 1; k < READ_LAT - 1; k++) pipe[k] <= pipe[k-1];
      end
    end
    assign resp = pipe[READ_LAT-2];
  end else begin : g_nopipe
    assign resp = s0;
  end

  assign resp_valid = resp.valid;
  assign resp_err   = resp.err;
  assign resp_rdata = resp.rdata;

endmodule
